// File: rtl/parking_system.sv
// Four-slot parking controller: synchronized, debounced sensors drive an
// occupancy vector that is shown on registered green/red slot LEDs.
module parking_system #(
  parameter int DEBOUNCE = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic sense_entry,
  input  logic sense_exit_A,
  input  logic sense_exit_B,
  input  logic sense_exit_C,
  input  logic sense_exit_D,
  output logic GledA,
  output logic GledB,
  output logic GledC,
  output logic GledD,
  output logic RledA,
  output logic RledB,
  output logic RledC,
  output logic RledD
);

  // Channel 0 is the entry sensor; channels 1..4 are the exits of slots A..D.
  logic [4:0] w_raw;
  logic [4:0] r_sync1;
  logic [4:0] r_sync2;
  logic [4:0] r_db;
  logic [4:0] r_db_prev;
  logic [7:0] r_cnt [5];
  logic [4:0] w_evt;
  logic [3:0] w_after_exit;
  logic [3:0] w_occ_next;
  logic [3:0] r_occ;
  logic [3:0] r_gled;

  assign w_raw = {sense_exit_D, sense_exit_C, sense_exit_B, sense_exit_A, sense_entry};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  // The counter tracks consecutive cycles of disagreement; the level flips
  // on the cycle that makes the run DEBOUNCE long.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_db      <= '0;
      r_db_prev <= '0;
      for (int unsigned k = 0; k < 5; k++) r_cnt[k] <= '0;
    end else begin
      r_db_prev <= r_db;
      for (int unsigned k = 0; k < 5; k++) begin
        if (r_sync2[k] != r_db[k]) begin
          if (r_cnt[k] == 8'(DEBOUNCE - 1)) begin
            r_db[k]  <= r_sync2[k];
            r_cnt[k] <= '0;
          end else begin
            r_cnt[k] <= r_cnt[k] + 8'd1;
          end
        end else begin
          r_cnt[k] <= '0;
        end
      end
    end
  end

  // Exits are applied before the entry allocates, so a slot freed in the
  // same cycle can be taken immediately.
  always_comb begin
    w_evt        = r_db & ~r_db_prev;
    w_after_exit = r_occ & ~w_evt[4:1];
    w_occ_next   = w_after_exit;
    if (w_evt[0]) begin
      casez (w_after_exit)
        4'b???0: w_occ_next[0] = 1'b1;
        4'b??01: w_occ_next[1] = 1'b1;
        4'b?011: w_occ_next[2] = 1'b1;
        4'b0111: w_occ_next[3] = 1'b1;
        default: w_occ_next = w_after_exit;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_occ  <= '0;
      r_gled <= '1;
    end else begin
      r_occ  <= w_occ_next;
      r_gled <= ~w_occ_next;
    end
  end

  assign RledA = r_occ[0];
  assign RledB = r_occ[1];
  assign RledC = r_occ[2];
  assign RledD = r_occ[3];
  assign GledA = r_gled[0];
  assign GledB = r_gled[1];
  assign GledC = r_gled[2];
  assign GledD = r_gled[3];

endmodule

// File: tb/tb_parking_system.sv
// Self-checking bench for parking_system: directed vector table, hand-written
// timing/reset sequences, and random sensor activity against a window model.
module tb_parking_system;

  localparam int D = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sense_entry = 1'b0;
  logic sense_exit_A = 1'b0;
  logic sense_exit_B = 1'b0;
  logic sense_exit_C = 1'b0;
  logic sense_exit_D = 1'b0;
  logic GledA, GledB, GledC, GledD;
  logic RledA, RledB, RledC, RledD;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_on = 1'b0;

  parking_system #(.DEBOUNCE(D)) dut (
    .clk(clk), .reset(reset), .sense_entry(sense_entry),
    .sense_exit_A(sense_exit_A), .sense_exit_B(sense_exit_B),
    .sense_exit_C(sense_exit_C), .sense_exit_D(sense_exit_D),
    .GledA(GledA), .GledB(GledB), .GledC(GledC), .GledD(GledD),
    .RledA(RledA), .RledB(RledB), .RledC(RledC), .RledD(RledD)
  );

  always #5 clk = ~clk;

  wire [3:0] rled = {RledD, RledC, RledB, RledA};
  wire [3:0] gled = {GledD, GledC, GledB, GledA};

  task automatic check(input string nm, input logic [3:0] act, input logic [3:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b (D..A) expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a debounced level flips when the last D synchronized
  // samples (raw samples 2..D+1 edges old) all disagree with it.
  bit [4:0][D+1:0] mh;
  bit [4:0] mdb, mdb_prev;
  bit [3:0] m_occ;

  function automatic bit [4:0] next_db(input bit [4:0][D+1:0] h, input bit [4:0] db);
    bit [4:0] r;
    for (int k = 0; k < 5; k++) begin
      bit all_diff;
      all_diff = 1'b1;
      for (int j = 1; j <= D; j++) if (h[k][j] == db[k]) all_diff = 1'b0;
      r[k] = all_diff ? ~db[k] : db[k];
    end
    return r;
  endfunction

  function automatic bit [3:0] next_occ(input bit [3:0] occ, input bit [4:0] evt);
    bit [3:0] n;
    bit done;
    n = occ & ~evt[4:1];
    done = 1'b0;
    if (evt[0])
      for (int x = 0; x < 4; x++)
        if (!done && !n[x]) begin
          n[x] = 1'b1;
          done = 1'b1;
        end
    return n;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mh       <= '0;
      mdb      <= '0;
      mdb_prev <= '0;
      m_occ    <= '0;
    end else begin
      m_occ    <= next_occ(m_occ, mdb & ~mdb_prev);
      mdb_prev <= mdb;
      mdb      <= next_db(mh, mdb);
      mh[0] <= {mh[0][D:0], sense_entry};
      mh[1] <= {mh[1][D:0], sense_exit_A};
      mh[2] <= {mh[2][D:0], sense_exit_B};
      mh[3] <= {mh[3][D:0], sense_exit_C};
      mh[4] <= {mh[4][D:0], sense_exit_D};
    end
  end

  always @(negedge clk) begin
    if (chk_on && !reset) begin
      check("model_rled", rled, m_occ);
      check("model_gled", gled, ~m_occ);
    end
  end

  typedef struct {
    logic       entry;
    logic [3:0] ex;
    int         hold;
    logic [3:0] exp_r;
    string      name;
  } vec_t;

  vec_t tbl[$];

  task automatic drive(input logic en, input logic [3:0] ex);
    sense_entry  = en;
    sense_exit_A = ex[0];
    sense_exit_B = ex[1];
    sense_exit_C = ex[2];
    sense_exit_D = ex[3];
  endtask

  initial begin
    tbl.push_back('{1'b0, 4'b0000, 10, 4'b0000, "idle"});
    tbl.push_back('{1'b1, 4'b0000, 50, 4'b0001, "entry1"});
    tbl.push_back('{1'b1, 4'b0000, 50, 4'b0011, "entry2"});
    tbl.push_back('{1'b1, 4'b0000, 50, 4'b0111, "entry3"});
    tbl.push_back('{1'b1, 4'b0000, 50, 4'b1111, "entry4"});
    tbl.push_back('{1'b1, 4'b0000, 50, 4'b1111, "entry_full"});
    tbl.push_back('{1'b0, 4'b0001, 50, 4'b1110, "exitA"});
    tbl.push_back('{1'b0, 4'b0001, 50, 4'b1110, "exitA_free"});
    tbl.push_back('{1'b0, 4'b0010, 50, 4'b1100, "exitB"});
    tbl.push_back('{1'b0, 4'b0100, 50, 4'b1000, "exitC"});
    tbl.push_back('{1'b0, 4'b1000, 50, 4'b0000, "exitD"});
    tbl.push_back('{1'b1, 4'b0000, 50, 4'b0001, "reentry"});
    tbl.push_back('{1'b1, 4'b0001, 50, 4'b0001, "exitA_entry"});
    tbl.push_back('{1'b1, 4'b0000, 50, 4'b0011, "entryB"});
    tbl.push_back('{1'b1, 4'b0000, 50, 4'b0111, "entryC"});
    tbl.push_back('{1'b0, 4'b0101, 50, 4'b0010, "multi_exit"});
    tbl.push_back('{1'b1, 4'b0000, D-1, 4'b0010, "glitch"});
    tbl.push_back('{1'b1, 4'b0000, 50, 4'b0011, "fillA"});
    tbl.push_back('{1'b1, 4'b0000, 50, 4'b0111, "fillC"});
    tbl.push_back('{1'b1, 4'b0000, 50, 4'b1111, "fillD"});

    repeat (3) @(negedge clk);
    check("reset_rled", rled, 4'b0000);
    check("reset_gled", gled, 4'b1111);
    reset = 1'b0;
    chk_on = 1'b1;

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i].entry, tbl[i].ex);
      repeat (tbl[i].hold) @(negedge clk);
      drive(1'b0, 4'b0000);
      repeat (50) @(negedge clk);
      check(tbl[i].name, rled, tbl[i].exp_r);
      check({tbl[i].name, "_g"}, gled, ~tbl[i].exp_r);
    end

    // Exit B with entry on the same cycle: no visible free interval.
    drive(1'b1, 4'b0010);
    for (int c = 0; c < 100; c++) begin
      if (c == 50) drive(1'b0, 4'b0000);
      @(negedge clk);
      check("swap_full", rled, 4'b1111);
    end

    // Exact-DEBOUNCE entry pulse: LED changes on edge D+3, not before.
    drive(1'b0, 4'b1000);
    repeat (50) @(negedge clk);
    drive(1'b0, 4'b0000);
    repeat (50) @(negedge clk);
    check("exitD_again", rled, 4'b0111);
    drive(1'b1, 4'b0000);
    repeat (D) @(negedge clk);
    drive(1'b0, 4'b0000);
    repeat (2) @(negedge clk);
    check("lat_before", rled, 4'b0111);
    @(negedge clk);
    check("lat_at", rled, 4'b1111);
    repeat (50) @(negedge clk);

    // Asynchronous reset between edges with three slots occupied.
    drive(1'b0, 4'b0001);
    repeat (50) @(negedge clk);
    drive(1'b0, 4'b0000);
    repeat (50) @(negedge clk);
    check("three_occ", rled, 4'b1110);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_rst_rled", rled, 4'b0000);
    check("async_rst_gled", gled, 4'b1111);
    drive(1'b1, 4'b0000);
    repeat (4) @(negedge clk);
    check("in_rst_rled", rled, 4'b0000);
    reset = 1'b0;
    repeat (D + 2) @(negedge clk);
    check("post_rst_before", rled, 4'b0000);
    @(negedge clk);
    check("post_rst_at", rled, 4'b0001);
    drive(1'b0, 4'b0000);
    repeat (50) @(negedge clk);

    // Random sensor activity, tracked by the reference model.
    for (int n = 0; n < 300; n++) begin
      logic [3:0] ex;
      for (int b = 0; b < 4; b++) ex[b] = ($urandom_range(0, 99) < 15);
      drive($urandom_range(0, 99) < 40, ex);
      repeat ($urandom_range(1, 2 * D + 3)) @(negedge clk);
    end
    drive(1'b0, 4'b0000);
    repeat (30) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
